lsb_mem_sequencer: RTL and testbench

Byte-serial data-side master for the memory controller's load/store-buffer port; the load/store counterpart of the instruction cache's byte-serial fill reader. Accepts one word-level load or store (LB/LH/LW/LBU/LHU/SB/SH/SW) from the load-store buffer. Issues 1, 2 or 4 little-endian byte accesses on lsb_*, assembles or extends the load result, and returns a one-cycle response.

---
 rtl/lsb_mem_sequencer.sv | 155 +++++++++++++++
 tb/tb_lsb_mem_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_mem_sequencer.sv
// Byte-serial load/store master: splits one LB/LH/LW/LBU/LHU/SB/SH/SW into
// little-endian byte accesses on lsb_* and returns a one-cycle response.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | driving byte k on lsb_*, waiting for lsb_valid
// DRAIN  | load only: last read byte arrives on lsb_read_data
// DONE   | resp_valid pulse with assembled/extended data
module lsb_mem_sequencer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic                  flush_in,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic [31:0]           lsb_addr,
  output logic [7:0]            lsb_data,
  output logic                  lsb_wr,
  output logic                  lsb_en,
  input  logic [7:0]            lsb_read_data,
  input  logic                  lsb_valid
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            k_q, k_d;
  logic [31:0]           asm_q, asm_d;
  logic                  cap_q, cap_d;
  logic [1:0]            cap_k_q, cap_k_d;

  logic [1:0]            last_k;
  logic                  flush_ld;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0]           ext_data;

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  // Stores are committed once accepted, so only loads honour flush.
  assign flush_ld = flush_in && !we_q;
  assign acc_addr = base_q + ADDR_WIDTH'(k_q);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    k_d      = k_q;
    asm_d    = asm_q;
    cap_d    = 1'b0;
    cap_k_d  = k_q;

    // Read byte lands one cycle after acceptance, whatever state we are in by then.
    if (cap_q) begin
      asm_d[{cap_k_q, 3'b000} +: 8] = lsb_read_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          base_d   = req_addr;
          wdata_d  = req_wdata;
          k_d      = 2'd0;
          asm_d    = 32'd0;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (flush_ld) begin
          state_d = ST_IDLE;
        end else if (lsb_valid) begin
          k_d     = k_q + 2'd1;
          cap_d   = !we_q;
          cap_k_d = k_q;
          if (k_q == last_k) begin
            state_d = we_q ? ST_DONE : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = flush_ld ? ST_IDLE : ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      base_q   <= '0;
      wdata_q  <= 32'd0;
      k_q      <= 2'd0;
      asm_q    <= 32'd0;
      cap_q    <= 1'b0;
      cap_k_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      k_q      <= k_d;
      asm_q    <= asm_d;
      cap_q    <= cap_d;
      cap_k_q  <= cap_k_d;
    end
  end

  always_comb begin
    case (funct3_q)
      3'b000:  ext_data = {{24{asm_q[7]}}, asm_q[7:0]};
      3'b100:  ext_data = {24'd0, asm_q[7:0]};
      3'b001:  ext_data = {{16{asm_q[15]}}, asm_q[15:0]};
      3'b101:  ext_data = {16'd0, asm_q[15:0]};
      default: ext_data = asm_q;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE) && !flush_ld;
  assign resp_data  = ((state_q == ST_DONE) && !we_q) ? ext_data : 32'd0;

  assign lsb_en   = (state_q == ST_ACCESS);
  assign lsb_wr   = lsb_en && we_q;
  assign lsb_addr = lsb_en ? 32'(acc_addr) : 32'd0;
  assign lsb_data = lsb_wr ? wdata_q[{k_q, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_lsb_mem_sequencer.sv
// Bench for lsb_mem_sequencer: a byte-memory responder with scripted or random
// stalls, table-driven directed vectors, corner sequences and random ops.
module tb_lsb_mem_sequencer;

  logic        clk_in, rst_in;
  logic        req_valid, req_ready, req_we, flush_in;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data, lsb_addr;
  logic [7:0]  lsb_data, lsb_read_data;
  logic        lsb_wr, lsb_en, lsb_valid;

  lsb_mem_sequencer #(.ADDR_WIDTH(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush_in(flush_in), .resp_valid(resp_valid), .resp_data(resp_data),
    .lsb_addr(lsb_addr), .lsb_data(lsb_data), .lsb_wr(lsb_wr), .lsb_en(lsb_en),
    .lsb_read_data(lsb_read_data), .lsb_valid(lsb_valid)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- memory model and responder ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  data;
    logic        v;
  } acc_t;

  logic [7:0]  mem [logic [31:0]];
  acc_t        cyc_q[$];
  acc_t        acc_q[$];
  bit          vscript[$];
  int          stall_pct = 0;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  initial begin
    bit          acc_prev;
    bit          v;
    logic [31:0] prev_addr;
    acc_t        e;
    acc_prev = 0;
    prev_addr = 0;
    lsb_valid = 1'b0;
    lsb_read_data = 8'h00;
    forever begin
      @(negedge clk_in);
      lsb_read_data = acc_prev ? mem_rd(prev_addr) : 8'($urandom);
      acc_prev = 0;
      if (lsb_en && rst_in) begin
        if (vscript.size() > 0) v = vscript.pop_front();
        else v = ($urandom_range(99) >= 32'(stall_pct));
        lsb_valid = v;
        e = '{addr: lsb_addr, wr: lsb_wr, data: lsb_data, v: v};
        cyc_q.push_back(e);
        if (v) begin
          acc_q.push_back(e);
          acc_prev = 1;
          prev_addr = lsb_addr;
          if (lsb_wr) mem[lsb_addr] = lsb_data;
        end
      end else begin
        lsb_valid = 1'b0;
      end
    end
  end

  // ---------------- reference rules ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] val;
    val = 0;
    for (int i = 0; i < nbytes(f3); i++) val = val | (32'(mem_rd(a + 32'(i))) << (8 * i));
    if (f3 == 3'b000 && val[7])  val = val | 32'hFFFF_FF00;
    if (f3 == 3'b001 && val[15]) val = val | 32'hFFFF_0000;
    return val;
  endfunction

  function automatic bit log_ok(input bit we, input logic [31:0] a, input logic [31:0] wd, input int n);
    logic [31:0] wv;
    if (acc_q.size() != n) return 0;
    for (int i = 0; i < n; i++) begin
      wv = wd >> (8 * i);
      if (acc_q[i].addr !== a + 32'(i)) return 0;
      if (acc_q[i].wr !== we) return 0;
      if (we && acc_q[i].data !== wv[7:0]) return 0;
    end
    return 1;
  endfunction

  // ---------------- one transaction ----------------
  task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int flush_cyc, input int max_cyc,
                       output bit got, output logic [31:0] rdata, output int lat,
                       output bit en_af, output bit rdy_af, output bit rdy_resp);
    int c;
    int w;
    got = 0; rdata = 0; lat = 0; en_af = 1; rdy_af = 0; rdy_resp = 1;
    @(negedge clk_in);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk_in);
      w++;
    end
    if (!req_ready) chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    cyc_q.delete();
    acc_q.delete();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    flush_in = (flush_cyc == 0);
    @(negedge clk_in);
    req_valid = 1'b0;
    c = 1;
    while (c <= max_cyc) begin
      if (c == flush_cyc + 1) begin
        en_af = lsb_en;
        rdy_af = req_ready;
      end
      if (resp_valid) begin
        got = 1; rdata = resp_data; lat = c; rdy_resp = req_ready;
        break;
      end
      flush_in = (c == flush_cyc);
      c++;
      @(negedge clk_in);
    end
    flush_in = 1'b0;
  endtask

  typedef struct {
    string       name;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          pre;
    logic [31:0] pre_bytes;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit          got, en_af, rdy_af, rdy_resp, ok;
    logic [31:0] rdata, exp, wd, addr, pb;
    logic [2:0]  f3;
    bit          we;
    int          lat, n, fc;
    logic [2:0]  f3_set[6];

    rst_in = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; flush_in = 1'b0;

    vecs.push_back('{"lw_1000",   0, 3'b010, 32'h0000_1000, 32'h0,         1, 32'h1234_5678, 32'h1234_5678, 6});
    vecs.push_back('{"lb_2003",   0, 3'b000, 32'h0000_2003, 32'h0,         1, 32'h0000_0080, 32'hFFFF_FF80, 3});
    vecs.push_back('{"lbu_2003",  0, 3'b100, 32'h0000_2003, 32'h0,         1, 32'h0000_0080, 32'h0000_0080, 3});
    vecs.push_back('{"lhu_2001",  0, 3'b101, 32'h0000_2001, 32'h0,         1, 32'h0000_F234, 32'h0000_F234, 4});
    vecs.push_back('{"lh_2001",   0, 3'b001, 32'h0000_2001, 32'h0,         1, 32'h0000_F234, 32'hFFFF_F234, 4});
    vecs.push_back('{"sh_3001",   1, 3'b001, 32'h0000_3001, 32'hDEAD_BEEF, 0, 32'h0,         32'h0,         3});
    vecs.push_back('{"lw_wrap",   0, 3'b010, 32'hFFFF_FFFE, 32'h0,         1, 32'h4433_2211, 32'h4433_2211, 6});
    vecs.push_back('{"f3_011",    0, 3'b011, 32'h0000_4000, 32'h0,         1, 32'hDDCC_BBAA, 32'hDDCC_BBAA, 6});
    vecs.push_back('{"sb_5000",   1, 3'b000, 32'h0000_5000, 32'h1234_56A5, 0, 32'h0,         32'h0,         2});
    vecs.push_back('{"lb_5000",   0, 3'b000, 32'h0000_5000, 32'h0,         0, 32'h0,         32'hFFFF_FFA5, 3});
    vecs.push_back('{"lh_pos",    0, 3'b001, 32'h0000_1000, 32'h0,         0, 32'h0,         32'h0000_5678, 4});
    vecs.push_back('{"sw_6000",   1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D, 0, 32'h0,         32'h0,         5});
    vecs.push_back('{"lw_6000",   0, 3'b010, 32'h0000_6000, 32'h0,         0, 32'h0,         32'hCAFE_F00D, 6});
    vecs.push_back('{"lhu_6002",  0, 3'b101, 32'h0000_6002, 32'h0,         0, 32'h0,         32'h0000_CAFE, 4});

    repeat (2) @(negedge clk_in);
    chk("rst_lsb_en", {31'd0, lsb_en}, 32'd0);
    chk("rst_lsb_wr", {31'd0, lsb_wr}, 32'd0);
    chk("rst_lsb_addr", lsb_addr, 32'd0);
    chk("rst_lsb_data", {24'd0, lsb_data}, 32'd0);
    chk("rst_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // directed table
    stall_pct = 0;
    foreach (vecs[i]) begin
      if (vecs[i].pre) begin
        pb = vecs[i].pre_bytes;
        for (int b = 0; b < 4; b++) begin
          mem[vecs[i].addr + 32'(b)] = pb[7:0];
          pb = pb >> 8;
        end
      end
      do_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, -5, 20,
            got, rdata, lat, en_af, rdy_af, rdy_resp);
      chk({vecs[i].name, "_got"}, {31'd0, got}, 32'd1);
      chk({vecs[i].name, "_data"}, rdata, vecs[i].exp);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      chk({vecs[i].name, "_ready_in_done"}, {31'd0, rdy_resp}, 32'd0);
      chk({vecs[i].name, "_accesses"},
          {31'd0, log_ok(vecs[i].we, vecs[i].addr, vecs[i].wd, nbytes(vecs[i].f3))}, 32'd1);
    end

    // stall of three cycles before byte 2
    vscript = '{1, 1, 0, 0, 0};
    do_op(0, 3'b010, 32'h0000_1000, 32'h0, -5, 30, got, rdata, lat, en_af, rdy_af, rdy_resp);
    chk("stall_data", rdata, 32'h1234_5678);
    chk("stall_lat", 32'(lat), 32'd9);
    ok = (cyc_q.size() == 7);
    for (int i = 2; i <= 5 && ok; i++) ok = (cyc_q[i].addr == 32'h0000_1002) && !cyc_q[i].wr;
    chk("stall_hold", {31'd0, ok}, 32'd1);

    // flush during byte 1 of a load
    do_op(0, 3'b010, 32'h0000_1000, 32'h0, 2, 12, got, rdata, lat, en_af, rdy_af, rdy_resp);
    chk("flush_lw_noresp", {31'd0, got}, 32'd0);
    chk("flush_lw_en", {31'd0, en_af}, 32'd0);
    chk("flush_lw_ready", {31'd0, rdy_af}, 32'd1);

    // flush during byte 1 of a store is ignored
    do_op(1, 3'b010, 32'h0000_8000, 32'h0A0B_0C0D, 2, 20, got, rdata, lat, en_af, rdy_af, rdy_resp);
    chk("flush_sw_got", {31'd0, got}, 32'd1);
    chk("flush_sw_lat", 32'(lat), 32'd5);
    chk("flush_sw_bytes", {31'd0, log_ok(1, 32'h0000_8000, 32'h0A0B_0C0D, 4)}, 32'd1);

    // request presented together with flush in IDLE is accepted
    do_op(0, 3'b010, 32'h0000_8000, 32'h0, 0, 20, got, rdata, lat, en_af, rdy_af, rdy_resp);
    chk("flush_idle_data", rdata, 32'h0A0B_0C0D);
    chk("flush_idle_lat", 32'(lat), 32'd6);

    // reset in the middle of a store after two bytes
    @(negedge clk_in);
    cyc_q.delete();
    acc_q.delete();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_7000; req_wdata = 32'h1122_3344;
    @(negedge clk_in);
    req_valid = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("rstmid_en", {31'd0, lsb_en}, 32'd0);
    chk("rstmid_resp", {31'd0, resp_valid}, 32'd0);
    chk("rstmid_bytes", 32'(acc_q.size()), 32'd2);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid_abandoned", {31'd0, mem.exists(32'h0000_7002)}, 32'd0);
    do_op(0, 3'b010, 32'h0000_1000, 32'h0, -5, 20, got, rdata, lat, en_af, rdy_af, rdy_resp);
    chk("rstmid_lw_data", rdata, 32'h1234_5678);
    chk("rstmid_lw_lat", 32'(lat), 32'd6);

    // randomized ops against the reference rules
    f3_set = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    stall_pct = 25;
    for (int t = 0; t < 80; t++) begin
      we = 1'($urandom_range(1));
      f3 = f3_set[$urandom_range(5)];
      if ($urandom_range(7) == 0) addr = 32'hFFFF_FFF0 + 32'($urandom_range(15));
      else addr = 32'h0000_9000 + 32'($urandom_range(63));
      wd = $urandom;
      n = nbytes(f3);
      fc = ($urandom_range(4) == 0) ? int'($urandom_range(n, 1)) : -5;
      exp = we ? 32'd0 : ref_load(f3, addr);
      do_op(we, f3, addr, wd, fc, 60, got, rdata, lat, en_af, rdy_af, rdy_resp);
      if (!we && fc > 0) begin
        chk("rand_flush_noresp", {31'd0, got}, 32'd0);
      end else begin
        chk("rand_got", {31'd0, got}, 32'd1);
        chk("rand_data", rdata, exp);
        chk("rand_lat", 32'(lat), 32'(n + (we ? 1 : 2) + (cyc_q.size() - acc_q.size())));
        chk("rand_accesses", {31'd0, log_ok(we, addr, wd, n)}, 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
